// File: rtl/fft_stage_ctrl_if.sv
// Control bundle between fft_stage_ctrl and the stage datapath: input handshake,
// delay-line/butterfly strobes, output framing and a state debug view.
interface fft_stage_ctrl_if #(
  parameter int TW_W = 4
);
  // Handshake: an input beat transfers on a cycle where valid_in and in_ready are
  // both 1; valid_in may be dropped at any time and in_ready does not wait for it.
  logic            valid_in;
  logic            in_ready;
  logic            sr_write;
  logic            sr_read;
  logic            bfly_en;
  logic [TW_W-1:0] tw_idx;
  logic            out_sel;
  logic            valid_out;
  logic            sop_out;
  logic            eop_out;
  logic            busy;
  logic            err_abort;
  logic [1:0]      dbg_state;

  modport master (
    input  valid_in,
    output in_ready, sr_write, sr_read, bfly_en, tw_idx, out_sel,
    output valid_out, sop_out, eop_out, busy, err_abort, dbg_state
  );

  modport slave (
    output valid_in,
    input  in_ready, sr_write, sr_read, bfly_en, tw_idx, out_sel,
    input  valid_out, sop_out, eop_out, busy, err_abort, dbg_state
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one radix-2 delay-feedback FFT stage (strobes, twiddle index, framing).
// Define FFT_STAGE_CTRL_ABORT_EN to abort a frame on an input gap; otherwise gaps stall.
module fft_stage_ctrl #(
  parameter int NUM      = 16,
  parameter int DATA     = 512,
  parameter int COUNT    = DATA / NUM,
  parameter int BFLY_LAT = 3
) (
  input logic              clk,
  input logic              rst,
  fft_stage_ctrl_if.master bus
);
  localparam int H  = COUNT / 2;
  localparam int CW = $clog2(COUNT);
  localparam int TW = $clog2(H);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_H    = CW'(H);
  localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);
  localparam logic [TW-1:0] DCNT_LAST = TW'(H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic sel;
    logic sop;
    logic eop;
  } pipe_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] dcnt;

  logic  in_ready;
  logic  accept;
  logic  bfly_en;
  logic  drain_rd;
  pipe_t entry;
  pipe_t pipe [BFLY_LAT];
  logic  pipe_any;

  assign in_ready = (state != DRAIN);
  assign accept   = bus.valid_in & in_ready;
  assign bfly_en  = (state == CALC) & bus.valid_in;
  assign drain_rd = (state == DRAIN);

  // Strobes are combinational so the datapath sees them in the beat's own cycle.
  assign bus.in_ready  = in_ready;
  assign bus.sr_write  = accept;
  assign bus.sr_read   = bfly_en | drain_rd;
  assign bus.bfly_en   = bfly_en;
  assign bus.tw_idx    = bfly_en ? cnt[TW-1:0] : '0;
  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CNT_ONE;
            state <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_HM1) state <= CALC;
          end
`ifdef FFT_STAGE_CTRL_ABORT_EN
          else begin
            cnt   <= '0;
            state <= IDLE;
          end
`endif
        end
        CALC: begin
          if (accept) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              dcnt  <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`ifdef FFT_STAGE_CTRL_ABORT_EN
          else begin
            cnt   <= '0;
            state <= IDLE;
          end
`endif
        end
        DRAIN: begin
          if (dcnt == DCNT_LAST) begin
            dcnt  <= '0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_STAGE_CTRL_ABORT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= ((state == FILL) || (state == CALC)) & ~bus.valid_in;
  end

  assign bus.err_abort = err_q;
`else
  assign bus.err_abort = 1'b0;
`endif

  // Framing travels with the butterfly latency so it lines up with the datapath output.
  always_comb begin
    entry       = '0;
    entry.valid = bfly_en | drain_rd;
    entry.sel   = drain_rd;
    entry.sop   = bfly_en & (cnt == CNT_H);
    entry.eop   = drain_rd & (dcnt == DCNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BFLY_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= entry;
      for (int i = 1; i < BFLY_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    pipe_any = 1'b0;
    for (int i = 0; i < BFLY_LAT; i++) pipe_any = pipe_any | pipe[i].valid;
  end

  assign bus.valid_out = pipe[BFLY_LAT-1].valid;
  assign bus.out_sel   = pipe[BFLY_LAT-1].sel;
  assign bus.sop_out   = pipe[BFLY_LAT-1].sop;
  assign bus.eop_out   = pipe[BFLY_LAT-1].eop;
  assign bus.busy      = (state != IDLE) | pipe_any;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at COUNT=32 (H=16), BFLY_LAT=3.
module tb_fft_stage_ctrl;
  localparam logic [13:0] IDLE_VEC = 14'h2000;
  localparam logic [13:0] GAP_VEC  = 14'h2002;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [13:0] obs;

  fft_stage_ctrl_if #(.TW_W(4)) bus ();

  fft_stage_ctrl #(
    .NUM(16), .DATA(512), .BFLY_LAT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, sr_write, sr_read, bfly_en, tw_idx[3:0], out_sel, valid_out, sop_out, eop_out, busy, err_abort}
  assign obs = {bus.in_ready, bus.sr_write, bus.sr_read, bus.bfly_en, bus.tw_idx,
                bus.out_sel, bus.valid_out, bus.sop_out, bus.eop_out, bus.busy, bus.err_abort};

  // Expected outputs k cycles after the first beat of an ungapped frame.
  function automatic logic [13:0] exp_vec(input int k, input logic v);
    logic ir, sw, sr, bf, os, vo, so, eo, bz;
    logic [3:0] tw;
    ir = !(k >= 32 && k <= 47);
    sw = (k >= 0 && k <= 31) ? 1'b1 : ((k < 0 || k >= 48) ? v : 1'b0);
    bf = (k >= 16 && k <= 31);
    tw = bf ? 4'(k - 16) : 4'd0;
    sr = (k >= 16 && k <= 47);
    vo = (k >= 19 && k <= 50);
    os = (k >= 35 && k <= 50);
    so = (k == 19);
    eo = (k == 50);
    bz = (k >= 1 && k <= 50);
    return {ir, sw, sr, bf, tw, os, vo, so, eo, bz, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (obs !== IDLE_VEC) $display("FAIL reset_outputs got %h exp %h", obs, IDLE_VEC);
    else pass_cnt++;
    total_cnt++;
    if (bus.dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", bus.dbg_state);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Single frame; valid_in toggles randomly during DRAIN and must be ignored.
  task automatic test_single_frame();
    logic v;
    logic [13:0] e;
    for (int k = -2; k <= 55; k++) begin
      if (k >= 32 && k <= 47) v = 1'($urandom_range(0, 1));
      else v = (k >= 0 && k <= 31);
      bus.valid_in = v;
      @(negedge clk);
      e = exp_vec(k, v);
      total_cnt++;
      if (obs !== e) $display("FAIL single_frame k=%0d got %h exp %h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [13:0] e, e1, e2;
    int vcount;
    vcount = 0;
    for (int k = 0; k <= 103; k++) begin
      v = (k <= 79);
      bus.valid_in = v;
      @(negedge clk);
      e1 = exp_vec(k, v);
      e2 = exp_vec(k - 48, v);
      e[13:6] = (k < 48) ? e1[13:6] : e2[13:6];
      e[5:0]  = e1[5:0] | e2[5:0];
      total_cnt++;
      if (obs !== e) $display("FAIL back_to_back k=%0d got %h exp %h", k, obs, e);
      else pass_cnt++;
      if (bus.valid_out === 1'b1) vcount++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (vcount !== 64) $display("FAIL b2b_valid_beats got %0d exp 64", vcount);
    else pass_cnt++;
  endtask

`ifdef FFT_STAGE_CTRL_ABORT_EN
  // Gap at beat 20 (CALC) aborts; issued outputs drain, no eop, then a normal frame.
  task automatic test_abort();
    logic v;
    logic [13:0] e;
    for (int k = -1; k <= 30; k++) begin
      v = (k >= 0 && k <= 19);
      bus.valid_in = v;
      @(negedge clk);
      if (k < 20) e = exp_vec(k, v);
      else e = {1'b1, 7'b0, 1'b0, (k <= 22), 1'b0, 1'b0, (k <= 22), (k == 21)};
      total_cnt++;
      if (obs !== e) $display("FAIL abort k=%0d got %h exp %h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    test_single_frame();
  endtask
`else
  // Five-cycle gap before beat 10 stalls the frame; everything after shifts by 5.
  task automatic test_stall();
    logic v;
    logic [13:0] e;
    for (int k = -2; k <= 60; k++) begin
      v = (k >= 0 && k <= 9) || (k >= 15 && k <= 36);
      bus.valid_in = v;
      @(negedge clk);
      if (k < 10) e = exp_vec(k, v);
      else if (k < 15) e = GAP_VEC;
      else e = exp_vec(k - 5, v);
      total_cnt++;
      if (obs !== e) $display("FAIL stall k=%0d got %h exp %h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask
`endif

  // Reset asserted during DRAIN (cycle 40) idles everything from cycle 41.
  task automatic test_reset_mid_drain();
    logic v;
    logic [13:0] e;
    for (int k = 0; k <= 55; k++) begin
      if (k >= 32 && k <= 40) v = 1'($urandom_range(0, 1));
      else v = (k <= 31);
      bus.valid_in = v;
      rst = (k == 40);
      @(negedge clk);
      e = (k <= 40) ? exp_vec(k, v) : IDLE_VEC;
      total_cnt++;
      if (obs !== e) $display("FAIL reset_drain k=%0d got %h exp %h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
`ifdef FFT_STAGE_CTRL_ABORT_EN
    test_abort();
`else
    test_stall();
`endif
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
